instr_encoder: RTL and testbench

Sequential MIPS instruction encoder: accepts symbolic instructions (mnemonic ID plus register and immediate fields) over a valid/ready handshake and writes the assembled 32-bit words to consecutive addresses through an instruction-memory write port. It produces exactly the encodings the main decoder consumes. It is used by the self-test loader and the program-injection bench to fill instruction memory before the core is released. When compiled in, it also expands the `li` pseudo-instruction into two words.

---
 rtl/instr_encoder.sv | 168 ++++++++++++++++
 tb/tb_instr_encoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder: symbolic request in, one encoded word per cycle out to imem.
// Define ENC_PSEUDO_EN to enable the two-word `li` pseudo-instruction (lui + ori).
module instr_encoder #(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [5:0]    i_mnem,
  input  logic [4:0]    i_rs,
  input  logic [4:0]    i_rt,
  input  logic [4:0]    i_rd,
  input  logic [4:0]    i_shamt,
  input  logic [15:0]   i_imm,
  input  logic [25:0]   i_target,
  input  logic          i_addr_ld,
  input  logic [AW-1:0] i_addr_val,
  output logic          o_imem_we,
  output logic [AW-1:0] o_imem_addr,
  output logic [31:0]   o_imem_wdata,
  output logic          o_err
);

`ifdef ENC_PSEUDO_EN
  typedef enum logic {IDLE, LI_LO} state_t;
  state_t      r_state;
  logic [4:0]  r_li_rt;
  logic [15:0] r_li_lo;
  logic        w_is_li;
`endif

  logic          r_we;
  logic [AW-1:0] r_addr_out;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic [AW-1:0] r_waddr;

  logic          w_accept;
  logic          w_legal;
  logic [31:0]   w_word;
  logic [AW-1:0] w_base;
  logic [19:0]   w_rfields;
  logic [25:0]   w_ifields;

`ifdef ENC_PSEUDO_EN
  assign o_in_ready = (r_state == IDLE);
`else
  assign o_in_ready = 1'b1;
`endif

  assign w_accept  = i_in_valid & o_in_ready;
  assign w_base    = i_addr_ld ? i_addr_val : r_waddr;
  assign w_rfields = {i_rs, i_rt, i_rd, i_shamt};
  assign w_ifields = {i_rs, i_rt, i_imm};

  // Fields are copied verbatim; only op/funct come from the mnemonic.
  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'h0;
`ifdef ENC_PSEUDO_EN
    w_is_li = 1'b0;
`endif
    case (i_mnem)
      6'd0:  w_word = {6'h00, w_rfields, 6'h00};
      6'd1:  w_word = {6'h00, w_rfields, 6'h02};
      6'd2:  w_word = {6'h00, w_rfields, 6'h03};
      6'd3:  w_word = {6'h00, w_rfields, 6'h04};
      6'd4:  w_word = {6'h00, w_rfields, 6'h06};
      6'd5:  w_word = {6'h00, w_rfields, 6'h07};
      6'd6:  w_word = {6'h00, w_rfields, 6'h08};
      6'd7:  w_word = {6'h00, w_rfields, 6'h09};
      6'd8:  w_word = {6'h00, w_rfields, 6'h19};
      6'd9:  w_word = {6'h00, w_rfields, 6'h20};
      6'd10: w_word = {6'h00, w_rfields, 6'h21};
      6'd11: w_word = {6'h00, w_rfields, 6'h22};
      6'd12: w_word = {6'h00, w_rfields, 6'h23};
      6'd13: w_word = {6'h00, w_rfields, 6'h24};
      6'd14: w_word = {6'h00, w_rfields, 6'h25};
      6'd15: w_word = {6'h00, w_rfields, 6'h26};
      6'd16: w_word = {6'h00, w_rfields, 6'h27};
      6'd17: w_word = {6'h00, w_rfields, 6'h2A};
      6'd18: w_word = {6'h00, w_rfields, 6'h2B};
      6'd19: w_word = {6'h04, w_ifields};
      6'd20: w_word = {6'h05, w_ifields};
      6'd21: w_word = {6'h06, w_ifields};
      6'd22: w_word = {6'h07, w_ifields};
      6'd23: w_word = {6'h08, w_ifields};
      6'd24: w_word = {6'h09, w_ifields};
      6'd25: w_word = {6'h0A, w_ifields};
      6'd26: w_word = {6'h0B, w_ifields};
      6'd27: w_word = {6'h0C, w_ifields};
      6'd28: w_word = {6'h0D, w_ifields};
      6'd29: w_word = {6'h0E, w_ifields};
      6'd30: w_word = {6'h0F, w_ifields};
      6'd31: w_word = {6'h1C, w_rfields, 6'h02};
      6'd32: w_word = {6'h20, w_ifields};
      6'd33: w_word = {6'h21, w_ifields};
      6'd34: w_word = {6'h23, w_ifields};
      6'd35: w_word = {6'h24, w_ifields};
      6'd36: w_word = {6'h25, w_ifields};
      6'd37: w_word = {6'h28, w_ifields};
      6'd38: w_word = {6'h29, w_ifields};
      6'd39: w_word = {6'h2B, w_ifields};
      6'd40: w_word = {6'h10, 5'd0, i_rt, i_rd, 11'd0};
      6'd41: w_word = {6'h02, i_target};
      6'd42: w_word = {6'h03, i_target};
`ifdef ENC_PSEUDO_EN
      6'd43: begin
        w_is_li = 1'b1;
        w_word  = {6'h0F, 5'd0, i_rt, i_imm};
      end
`endif
      default: w_legal = 1'b0;
    endcase
  end

  // addr_ld always retargets the next emitted word, including the li low half.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_we       <= 1'b0;
      r_addr_out <= '0;
      r_wdata    <= 32'h0;
      r_err      <= 1'b0;
      r_waddr    <= '0;
`ifdef ENC_PSEUDO_EN
      r_state    <= IDLE;
      r_li_rt    <= 5'd0;
      r_li_lo    <= 16'h0;
`endif
    end else begin
      r_we    <= 1'b0;
      r_waddr <= w_base;
`ifdef ENC_PSEUDO_EN
      if (r_state == LI_LO) begin
        r_we       <= 1'b1;
        r_addr_out <= w_base;
        r_wdata    <= {6'h0D, r_li_rt, r_li_rt, r_li_lo};
        r_waddr    <= w_base + AW'(1);
        r_state    <= IDLE;
      end else
`endif
      if (w_accept) begin
        if (w_legal) begin
          r_we       <= 1'b1;
          r_addr_out <= w_base;
          r_wdata    <= w_word;
          r_waddr    <= w_base + AW'(1);
`ifdef ENC_PSEUDO_EN
          if (w_is_li) begin
            r_state <= LI_LO;
            r_li_rt <= i_rt;
            r_li_lo <= i_target[15:0];
          end
`endif
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr_out;
  assign o_imem_wdata = r_wdata;
  assign o_err        = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table plus li / reset / wrap sequences, scoreboarded writes.
module tb_instr_encoder;
  localparam int AW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [5:0]    i_mnem = '0;
  logic [4:0]    i_rs = '0, i_rt = '0, i_rd = '0, i_shamt = '0;
  logic [15:0]   i_imm = '0;
  logic [25:0]   i_target = '0;
  logic          i_addr_ld = 1'b0;
  logic [AW-1:0] i_addr_val = '0;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata;
  logic          o_err;

  instr_encoder #(.AW(AW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_mnem(i_mnem), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
    .i_imm(i_imm), .i_target(i_target), .i_addr_ld(i_addr_ld), .i_addr_val(i_addr_val),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0]  mnem;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t          sb[$];
  vec_t          vecs[15];
  vec_t          v;
  logic [AW-1:0] expAddr = '0;
  int            nCompared = 0;
  int            nMismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Every write strobe must match the oldest pending expectation.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", o_imem_addr, o_imem_wdata);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_addr", 32'(o_imem_addr), 32'(e.addr));
        checkOutput("wr_data", o_imem_wdata, e.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic driveFields(input vec_t x);
    i_mnem = x.mnem; i_rs = x.rs; i_rt = x.rt; i_rd = x.rd; i_shamt = x.shamt;
    i_imm = x.imm; i_target = x.target;
  endtask

  task automatic applyStimulus(input vec_t x, input bit ld, input logic [AW-1:0] ldVal);
    checkOutput("in_ready_before_accept", 32'(o_in_ready), 32'd1);
    driveFields(x);
    i_in_valid = 1'b1;
    i_addr_ld  = ld;
    i_addr_val = ldVal;
    if (ld) expAddr = ldVal;
    if (x.legal) begin
      sb.push_back('{expAddr, x.word});
      expAddr = expAddr + 1'b1;
    end
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    i_addr_ld  = 1'b0;
  endtask

  task automatic resetDut();
    i_reset_n  = 1'b0;
    i_in_valid = 1'b0;
    idle(2);
    checkOutput("rst_we", 32'(o_imem_we), 32'd0);
    checkOutput("rst_addr", 32'(o_imem_addr), 32'd0);
    checkOutput("rst_wdata", o_imem_wdata, 32'd0);
    checkOutput("rst_err", 32'(o_err), 32'd0);
    checkOutput("rst_in_ready", 32'(o_in_ready), 32'd1);
    checkOutput("sb_empty_at_reset", 32'(sb.size()), 32'd0);
    i_reset_n = 1'b1;
    expAddr   = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{6'd9,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 26'h0000000, 1'b1, 32'h00221820};
    vecs[1]  = '{6'd23, 5'd0,  5'd8,  5'd0,  5'd0, 16'hFFFF, 26'h0000000, 1'b1, 32'h2008FFFF};
    vecs[2]  = '{6'd41, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h0100000, 1'b1, 32'h08100000};
    vecs[3]  = '{6'd0,  5'd0,  5'd2,  5'd4,  5'd5, 16'h0000, 26'h0000000, 1'b1, 32'h00022140};
    vecs[4]  = '{6'd18, 5'd3,  5'd4,  5'd5,  5'd0, 16'h0000, 26'h0000000, 1'b1, 32'h0064282B};
    vecs[5]  = '{6'd39, 5'd29, 5'd31, 5'd0,  5'd0, 16'h0010, 26'h0000000, 1'b1, 32'hAFBF0010};
    vecs[6]  = '{6'd31, 5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 26'h0000000, 1'b1, 32'h70221802};
    vecs[7]  = '{6'd40, 5'd7,  5'd8,  5'd12, 5'd3, 16'h0000, 26'h0000000, 1'b1, 32'h40086000};
    vecs[8]  = '{6'd42, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h3FFFFFF, 1'b1, 32'h0FFFFFFF};
    vecs[9]  = '{6'd30, 5'd0,  5'd5,  5'd0,  5'd0, 16'hABCD, 26'h0000000, 1'b1, 32'h3C05ABCD};
    vecs[10] = '{6'd8,  5'd2,  5'd3,  5'd0,  5'd0, 16'h0000, 26'h0000000, 1'b1, 32'h00430019};
    vecs[11] = '{6'd20, 5'd1,  5'd2,  5'd0,  5'd0, 16'hFFFE, 26'h0000000, 1'b1, 32'h1422FFFE};
    vecs[12] = '{6'd63, 5'd1,  5'd2,  5'd3,  5'd0, 16'h1111, 26'h0000000, 1'b0, 32'h00000000};
    vecs[13] = '{6'd34, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h0000000, 1'b1, 32'h8C000000};
    vecs[14] = '{6'd16, 5'd6,  5'd7,  5'd8,  5'd0, 16'h0000, 26'h0000000, 1'b1, 32'h00C74027};

    resetDut();

    // Back-to-back table; the illegal entry must not consume an address.
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], 1'b0, '0);
    idle(2);
    checkOutput("err_after_illegal", 32'(o_err), 32'd1);
    checkOutput("sb_drained_table", 32'(sb.size()), 32'd0);

    // Address load coinciding with an accept, then wrap from 15 to 0.
    applyStimulus(vecs[0], 1'b1, 4'd15);
    v = '{6'd14, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0000000, 1'b1, 32'h00221825};
    applyStimulus(v, 1'b0, '0);
    idle(2);
    checkOutput("err_sticky", 32'(o_err), 32'd1);
    checkOutput("sb_drained_wrap", 32'(sb.size()), 32'd0);

    resetDut();
    v = '{6'd43, 5'd0, 5'd9, 5'd0, 5'd0, 16'h1234, 26'h0005678, 1'b0, 32'h0};
`ifdef ENC_PSEUDO_EN
    driveFields(v);
    i_in_valid = 1'b1;
    sb.push_back('{expAddr, 32'h3C091234});
    sb.push_back('{expAddr + 1'b1, 32'h35295678});
    expAddr = expAddr + 2'd2;
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    checkOutput("li_in_ready_low", 32'(o_in_ready), 32'd0);
    idle(1);
    checkOutput("li_in_ready_back", 32'(o_in_ready), 32'd1);
    idle(2);
    checkOutput("li_err_clear", 32'(o_err), 32'd0);
    checkOutput("sb_drained_li", 32'(sb.size()), 32'd0);

    // Reset while the ori half is pending: only the lui half may appear.
    v = '{6'd43, 5'd0, 5'd10, 5'd0, 5'd0, 16'h00AA, 26'h00000BB, 1'b0, 32'h0};
    driveFields(v);
    i_in_valid = 1'b1;
    sb.push_back('{expAddr, 32'h3C0A00AA});
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    i_reset_n  = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("li_reset_we", 32'(o_imem_we), 32'd0);
    checkOutput("li_reset_in_ready", 32'(o_in_ready), 32'd1);
    i_reset_n = 1'b1;
    expAddr   = '0;
    idle(3);
    checkOutput("sb_drained_li_reset", 32'(sb.size()), 32'd0);
`else
    driveFields(v);
    i_in_valid = 1'b1;
    checkOutput("li_off_ready_pre", 32'(o_in_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    checkOutput("li_off_ready_post", 32'(o_in_ready), 32'd1);
    checkOutput("li_off_err", 32'(o_err), 32'd1);
    idle(2);
    checkOutput("li_off_ready_later", 32'(o_in_ready), 32'd1);
    applyStimulus(vecs[0], 1'b0, '0);
    idle(2);
    checkOutput("sb_drained_li_off", 32'(sb.size()), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
